// File: rtl/fetch_unit_btb_if.sv
// Fetch-stage bundle between decode/hazard logic (master) and the BTB-based
// fetch unit (slave): redirects, predictor updates and IF-side outputs.
interface fetch_unit_btb_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 stall;
  logic                 redirect_valid;
  logic [WIDTH-1:0]     redirect_pc;
  logic                 upd_valid;
  logic [WIDTH-1:0]     upd_pc;
  logic                 upd_taken;
  logic [WIDTH-1:0]     upd_target;
  logic [WIDTH-1:0]     pc_if;
  logic [WIDTH-1:0]     pcplus4_if;
  logic                 pred_taken_if;
  logic [WIDTH-1:0]     pred_target_if;
  logic                 flush_id;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pc_if, pcplus4_if, pred_taken_if, pred_target_if, flush_id, mispredict_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pc_if, pcplus4_if, pred_taken_if, pred_target_if, flush_id, mispredict_count
  );
endinterface

// File: rtl/fetch_unit_btb.sv
// Instruction-fetch stage: PC register plus a direct-mapped BTB with 2-bit
// saturating predictors, decode-driven redirects and a mispredict counter.
module fetch_unit_btb #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      CNT_WIDTH   = 16
) (
  input logic                clk,
  input logic                reset,
  fetch_unit_btb_if.slave    bus
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = WIDTH - IDX - 2;

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     pcplus4;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_q [BTB_ENTRIES];
  logic [1:0]             cnt_q    [BTB_ENTRIES];

  // Lookup on the current fetch PC
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;

  assign look_idx    = pc_q[IDX+1:2];
  assign look_tag    = pc_q[WIDTH-1:IDX+2];
  assign look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred_taken  = look_hit && cnt_q[look_idx][1];
  assign pred_target = look_hit ? target_q[look_idx] : '0;
  assign pcplus4     = pc_q + WIDTH'(4);

  // Update-port decode
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_cnt_old;
  logic [1:0]       upd_cnt_new;

  assign upd_idx     = bus.upd_pc[IDX+1:2];
  assign upd_tag     = bus.upd_pc[WIDTH-1:IDX+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_cnt_old = cnt_q[upd_idx];

  always_comb begin
    upd_cnt_new = upd_cnt_old;
    if (bus.upd_taken) begin
      if (upd_cnt_old != 2'b11) upd_cnt_new = upd_cnt_old + 2'd1;
    end else begin
      if (upd_cnt_old != 2'b00) upd_cnt_new = upd_cnt_old - 2'd1;
    end
  end

  // Redirect beats stall; stall beats prediction
  always_comb begin
    pc_d = pcplus4;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    if (bus.redirect_valid && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      mcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      mcnt_q <= mcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= upd_cnt_new;
        if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        // Allocation replaces whatever alias occupied the slot
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.upd_target;
        cnt_q[upd_idx]    <= 2'b10;
      end
    end
  end

  logic unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^bus.upd_pc[1:0];

  assign bus.pc_if            = pc_q;
  assign bus.pcplus4_if       = pcplus4;
  assign bus.pred_taken_if    = pred_taken;
  assign bus.pred_target_if   = pred_target;
  assign bus.flush_id         = bus.redirect_valid;
  assign bus.mispredict_count = mcnt_q;

endmodule

// File: tb/tb_fetch_unit_btb.sv
// Scoreboard bench for fetch_unit_btb: directed cycles push expected outputs,
// a monitor pops and compares them mid-cycle.
module tb_fetch_unit_btb;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_btb_if #(.WIDTH(32), .CNT_WIDTH(2)) bus ();

  fetch_unit_btb #(
    .WIDTH      (32),
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        fl;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge and queue that cycle's outputs
  task automatic step(input string name, input logic rst, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic [31:0] e_pc,
                      input logic e_pt, input logic [31:0] e_ptg, input logic [1:0] e_cnt);
    exp_t e;
    @(negedge clk);
    reset              = rst;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utg;
    e.name = name;
    e.pc   = e_pc;
    e.pt   = e_pt;
    e.ptg  = e_ptg;
    e.fl   = rv;
    e.cnt  = e_cnt;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "pc_if",   bus.pc_if,                     e.pc);
        chk(e.name, "pcplus4", bus.pcplus4_if,                e.pc + 32'd4);
        chk(e.name, "pred_t",  {31'd0, bus.pred_taken_if},    {31'd0, e.pt});
        chk(e.name, "pred_tg", bus.pred_target_if,            e.ptg);
        chk(e.name, "flush",   {31'd0, bus.flush_id},         {31'd0, e.fl});
        chk(e.name, "mcount",  {30'd0, bus.mispredict_count}, {30'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    @(posedge clk);
    //    name        rst st rv rpc            uv upc     ut utg        pc            pt ptg      cnt
    step("reset",     1, 0, 0, 0,             0, 0,      0, 0,         32'h0,        0, 0,       0);
    step("run0",      0, 0, 0, 0,             0, 0,      0, 0,         32'h0,        0, 0,       0);
    step("run4",      0, 0, 0, 0,             0, 0,      0, 0,         32'h4,        0, 0,       0);
    step("run8",      0, 0, 0, 0,             0, 0,      0, 0,         32'h8,        0, 0,       0);
    step("alloc",     0, 0, 0, 0,             1, 32'h10, 1, 32'h40,    32'hC,        0, 0,       0);
    step("predT",     0, 0, 0, 0,             0, 0,      0, 0,         32'h10,       1, 32'h40,  0);
    step("tgt40",     0, 0, 0, 0,             1, 32'h10, 0, 0,         32'h40,       0, 0,       0);
    step("redir1",    0, 0, 1, 32'h10,        0, 0,      0, 0,         32'h44,       0, 0,       0);
    step("weakNT",    0, 0, 0, 0,             1, 32'h10, 1, 32'h40,    32'h10,       0, 32'h40,  1);
    step("fall14",    0, 0, 0, 0,             0, 0,      0, 0,         32'h14,       0, 0,       1);
    step("redir2",    0, 0, 1, 32'h10,        0, 0,      0, 0,         32'h18,       0, 0,       1);
    step("weakT",     0, 0, 0, 0,             1, 32'h10, 0, 0,         32'h10,       1, 32'h40,  2);
    step("nt2",       0, 0, 0, 0,             1, 32'h10, 0, 0,         32'h40,       0, 0,       2);
    step("ntsat",     0, 0, 0, 0,             1, 32'h10, 0, 0,         32'h44,       0, 0,       2);
    step("tk01",      0, 0, 0, 0,             1, 32'h10, 1, 32'h40,    32'h48,       0, 0,       2);
    step("redir3",    0, 0, 1, 32'h10,        0, 0,      0, 0,         32'h4C,       0, 0,       2);
    step("satNT",     0, 0, 0, 0,             0, 0,      0, 0,         32'h10,       0, 32'h40,  3);
    step("redirSat",  0, 0, 1, 32'h50,        0, 0,      0, 0,         32'h14,       0, 0,       3);
    step("alias",     0, 0, 0, 0,             1, 32'h50, 1, 32'h80,    32'h50,       0, 0,       3);
    step("redir5",    0, 0, 1, 32'h10,        0, 0,      0, 0,         32'h54,       0, 0,       3);
    step("evicted",   0, 0, 0, 0,             0, 0,      0, 0,         32'h10,       0, 0,       3);
    step("redir6",    0, 0, 1, 32'h50,        0, 0,      0, 0,         32'h14,       0, 0,       3);
    step("aliasT",    0, 0, 0, 0,             0, 0,      0, 0,         32'h50,       1, 32'h80,  3);
    step("midrst",    1, 0, 1, 32'h300,       1, 32'h80, 1, 32'h200,   32'h80,       0, 0,       3);
    step("postrst",   0, 0, 1, 32'h50,        0, 0,      0, 0,         32'h0,        0, 0,       0);
    step("inval50",   0, 0, 1, 32'h80,        0, 0,      0, 0,         32'h50,       0, 0,       1);
    step("inval80",   1, 0, 0, 0,             0, 0,      0, 0,         32'h80,       0, 0,       2);
    for (int i = 0; i < 8; i++) begin
      step("seq",     0, 0, 0, 0,             0, 0,      0, 0,         32'(4 * i),   0, 0,       0);
    end
    step("stall1",    0, 1, 0, 0,             0, 0,      0, 0,         32'h20,       0, 0,       0);
    step("stallRd",   0, 1, 1, 32'h100,       0, 0,      0, 0,         32'h20,       0, 0,       0);
    step("stall3",    0, 1, 0, 0,             0, 0,      0, 0,         32'h100,      0, 0,       1);
    step("unstall",   0, 0, 0, 0,             0, 0,      0, 0,         32'h100,      0, 0,       1);
    step("redirTop",  0, 0, 1, 32'hFFFF_FFFC, 0, 0,      0, 0,         32'h104,      0, 0,       1);
    step("top",       0, 0, 0, 0,             0, 0,      0, 0,         32'hFFFF_FFFC, 0, 0,      2);
    step("wrap",      0, 0, 0, 0,             0, 0,      0, 0,         32'h0,        0, 0,       2);
    @(negedge clk);
    #5;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
